// File: rtl/icache_pkg.sv
// Shared types, field widths and PC field extraction for the instruction cache.
// Widths correspond to the default geometry: 8 sets, 4 words per block.
package icache_pkg;

  localparam int unsigned INDEX_W  = 3;
  localparam int unsigned OFFSET_W = 2;
  localparam int unsigned TAG_W    = 32 - INDEX_W - OFFSET_W - 2;
  localparam int unsigned BLOCK_W  = 32 * (1 << OFFSET_W);

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    UPDATE
  } state_e;

  function automatic logic [OFFSET_W-1:0] pc_offset(input logic [31:0] pc);
    return pc[OFFSET_W+1:2];
  endfunction

  function automatic logic [INDEX_W-1:0] pc_index(input logic [31:0] pc);
    return pc[INDEX_W+OFFSET_W+1:OFFSET_W+2];
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
    return pc[31:32-TAG_W];
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: combinational read port, synchronous single-line
// write port, and asynchronous clear of all valid bits.
module icache_line_array #(
  parameter int unsigned NUM_SETS = 8,
  parameter int unsigned TAG_W    = 25,
  parameter int unsigned LINE_W   = 128
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [$clog2(NUM_SETS)-1:0] rd_index_i,
  output logic                        rd_valid_o,
  output logic [TAG_W-1:0]            rd_tag_o,
  output logic [LINE_W-1:0]           rd_data_o,
  input  logic                        wr_en_i,
  input  logic [$clog2(NUM_SETS)-1:0] wr_index_i,
  input  logic [TAG_W-1:0]            wr_tag_i,
  input  logic [LINE_W-1:0]           wr_data_i
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data are meaningless while the valid bit is clear, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/instruction_cache_ctrl.sv
// Direct-mapped read-only instruction cache with a combinational hit path and
// block refill FSM. Optional hit/miss counters under ICACHE_PERF_COUNTERS_EN.
module instruction_cache_ctrl #(
  parameter int unsigned NUM_SETS        = 8,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned TAG_W           = 25
) (
  input  logic                                 CLK,
  input  logic                                 RESET,
  input  logic [31:0]                          PC,
  output logic [31:0]                          instruction,
  output logic                                 busyWait,
  output logic                                 mem_read,
  output logic [TAG_W+$clog2(NUM_SETS)-1:0]    mem_address,
  input  logic [32*WORDS_PER_BLOCK-1:0]        mem_readdata,
  input  logic                                 mem_busyWait
`ifdef ICACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]                          hit_count,
  output logic [31:0]                          miss_count
`endif
);

  import icache_pkg::*;

  localparam int unsigned IDX_W  = $clog2(NUM_SETS);
  localparam int unsigned OFF_W  = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned BA_W   = TAG_W + IDX_W;
  localparam int unsigned LINE_W = 32 * WORDS_PER_BLOCK;

  logic [IDX_W-1:0]  index;
  logic [OFF_W-1:0]  offset;
  logic [TAG_W-1:0]  tag;

  state_e            state_q;
  logic              mem_read_q;
  logic [BA_W-1:0]   req_q;

  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [LINE_W-1:0] line_data;
  logic [WORDS_PER_BLOCK-1:0][31:0] line_words;
  logic              hit;
  logic              fill_en;

  assign index  = pc_index(PC);
  assign offset = pc_offset(PC);
  assign tag    = pc_tag(PC);

  icache_line_array #(
    .NUM_SETS (NUM_SETS),
    .TAG_W    (TAG_W),
    .LINE_W   (LINE_W)
  ) u_lines (
    .clk_i      (CLK),
    .rst_ni     (RESET),
    .rd_index_i (index),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data),
    .wr_en_i    (fill_en),
    .wr_index_i (req_q[IDX_W-1:0]),
    .wr_tag_i   (req_q[BA_W-1:IDX_W]),
    .wr_data_i  (mem_readdata)
  );

  assign line_words  = line_data;
  assign hit         = line_valid && (line_tag == tag);
  assign fill_en     = (state_q == MEM_READ) && !mem_busyWait;

  // Gating with hit keeps never-written data words off the output.
  assign instruction = (RESET && hit) ? line_words[offset] : '0;
  assign busyWait    = RESET && ((state_q != IDLE) || !hit);
  assign mem_read    = mem_read_q;
  assign mem_address = req_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      mem_read_q <= 1'b0;
      req_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!hit) begin
            req_q      <= {tag, index};
            mem_read_q <= 1'b1;
            state_q    <= MEM_READ;
          end
        end
        MEM_READ: begin
          if (!mem_busyWait) begin
            mem_read_q <= 1'b0;
            state_q    <= UPDATE;
          end
        end
        UPDATE: begin
          state_q <= IDLE;
        end
        default: begin
          mem_read_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (hit && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (!hit && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_cache_ctrl.sv
// Scoreboard bench for instruction_cache_ctrl: a high-level cache model predicts
// hits, refill requests and stall lengths; a monitor checks DUT responses.
module tb_instruction_cache_ctrl;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic [31:0]  PC = 32'h0;
  logic [31:0]  instruction;
  logic         busyWait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata = '0;
  logic         mem_busyWait = 1'b0;
`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  instruction_cache_ctrl dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .instruction  (instruction),
    .busyWait     (busyWait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busyWait (mem_busyWait)
`ifdef ICACHE_PERF_COUNTERS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          stall;
  } exp_t;

  exp_t        exp_q[$];
  logic [27:0] req_q[$];
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int mem_lat = 1;
  int misses = 0;

  bit          mv[8];
  logic [24:0] mtag[8];

  function automatic logic [31:0] memword(input logic [27:0] blk, input logic [1:0] w);
    return {2'b10, blk, w} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: stays busy for (mem_lat-1) cycles, so a fill spends mem_lat edges in MEM_READ.
  int mcnt = 0;
  always @(negedge CLK) begin
    if (mem_read) begin
      if (mcnt < mem_lat - 1) begin
        mem_busyWait = 1'b1;
        mcnt++;
      end else begin
        mem_busyWait = 1'b0;
        for (int w = 0; w < 4; w++) mem_readdata[w*32 +: 32] = memword(mem_address, 2'(w));
      end
    end else begin
      mem_busyWait = 1'b0;
      mcnt = 0;
    end
  end

  // Monitor: checks refill requests and every delivered instruction.
  int   stall = 0;
  logic prev_mr = 1'b0;
  always @(negedge CLK) begin
    if (!RESET) begin
      stall = 0;
    end else begin
      if (mem_read && !prev_mr) begin
        if (req_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_mem_read: got address %h expected no request", mem_address);
        end else begin
          logic [27:0] ea;
          ea = req_q.pop_front();
          check("mem_address", {4'h0, mem_address}, {4'h0, ea});
        end
      end
      if (busyWait) begin
        stall++;
      end else if (exp_q.size() > 0) begin
        exp_t x;
        x = exp_q.pop_front();
        check("instruction", instruction, x.instr);
        if (x.stall >= 0) check("stall_cycles", stall, x.stall);
        stall = 0;
        done_cnt++;
      end
    end
    prev_mr = mem_read;
  end

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Model lookup; on a miss the request is expected and the block is installed.
  function automatic bit model_access(input logic [31:0] pc);
    int          idx;
    logic [24:0] t;
    idx = int'((pc / 16) % 8);
    t   = pc[31:7];
    if (mv[idx] && mtag[idx] == t) return 1'b1;
    req_q.push_back(pc[31:4]);
    mv[idx]   = 1'b1;
    mtag[idx] = t;
    misses++;
    return 1'b0;
  endfunction

  task automatic wait_done(input int start);
    for (int n = 0; n < 100 && done_cnt == start; n++) @(posedge CLK);
    if (done_cnt == start) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no response for PC %h expected one within 100 cycles", PC);
      finish_run();
    end
  endtask

  task automatic issue(input logic [31:0] pc, input int lat, input bit release_rst);
    exp_t x;
    int   start;
    bit   h;
    @(posedge CLK);
    #1;
    start   = done_cnt;
    mem_lat = lat;
    PC      = pc;
    if (release_rst) RESET = 1'b1;
    h       = model_access(pc);
    x.pc    = pc;
    x.instr = memword(pc[31:4], pc[3:2]);
    x.stall = h ? 0 : lat + 2;
    exp_q.push_back(x);
    wait_done(start);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    misses = 0;
  endtask

  initial begin
    int   start;
    exp_t x;
    bit   h;

    model_reset();
    #2;
    check("reset_busyWait", {31'h0, busyWait}, 32'h0);
    check("reset_mem_read", {31'h0, mem_read}, 32'h0);
    check("reset_instruction", instruction, 32'h0);
`ifdef ICACHE_PERF_COUNTERS_EN
    check("reset_hit_count", hit_count, 32'h0);
    check("reset_miss_count", miss_count, 32'h0);
`endif
    repeat (2) @(posedge CLK);

    // Cold start, hits within the block, conflict eviction.
    issue(32'h0000_0000, 3, 1'b1);
    issue(32'h0000_0004, 3, 1'b0);
    issue(32'h0000_0008, 3, 1'b0);
    issue(32'h0000_000C, 3, 1'b0);
    issue(32'h0000_0080, 2, 1'b0);
    issue(32'h0000_0000, 1, 1'b0);
    issue(32'hFFFF_FFFC, 4, 1'b0);
    issue(32'hFFFF_FFF1, 1, 1'b0);

    // PC moves while the 0x10 fill is outstanding.
    @(posedge CLK);
    #1;
    start   = done_cnt;
    mem_lat = 3;
    PC      = 32'h0000_0010;
    h       = model_access(PC);
    repeat (2) @(posedge CLK);
    #1;
    PC      = 32'h0000_0020;
    h       = model_access(PC);
    x.pc    = PC;
    x.instr = memword(28'h2, 2'd0);
    x.stall = -1;
    exp_q.push_back(x);
    wait_done(start);
    issue(32'h0000_0014, 2, 1'b0);

    // Reset asserted in the middle of a fill.
    @(posedge CLK);
    #1;
    mem_lat = 5;
    PC      = 32'h0000_0300;
    h       = model_access(PC);
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
    #1;
    check("midfill_mem_read", {31'h0, mem_read}, 32'h0);
    check("midfill_busyWait", {31'h0, busyWait}, 32'h0);
    check("midfill_instruction", instruction, 32'h0);
    repeat (2) @(posedge CLK);
    issue(32'h0000_0000, 2, 1'b1);

    // Random fetches over a small address space to mix hits and conflicts.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) |
           ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      issue(pc, int'($urandom_range(1, 5)), 1'b0);
    end

`ifdef ICACHE_PERF_COUNTERS_EN
    check("miss_count", miss_count, misses);
    tests++;
    if (hit_count == 32'h0) begin
      fails++;
      $display("FAIL hit_count: got %h expected nonzero", hit_count);
    end
`endif

    repeat (2) @(posedge CLK);
    check("drain_exp_queue", exp_q.size(), 32'h0);
    check("drain_req_queue", req_q.size(), 32'h0);
    finish_run();
  end

endmodule
